lcd_bus_writer: RTL

LCD_BUS_WRITER -- requirements
Module: lcd_bus_writer

---
 rtl/lcd_bus_writer_if.sv | 21 ++
 rtl/lcd_bus_writer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_writer_if.sv
// Symbol input handshake and HD44780-style write bus of lcd_bus_writer.
// A symbol transfers on a rising clk edge where data_valid_i=1 and ready_o=1; with ready_o=0 the inputs are ignored.
interface lcd_bus_writer_if;
  logic [8:0] data_i;
  logic       data_valid_i;
  logic       ready_o;
  logic       lcd_rs_o;
  logic       lcd_rw_o;
  logic       lcd_e_o;
  logic [7:0] lcd_db_o;

  modport master (
    output data_i, data_valid_i,
    input  ready_o, lcd_rs_o, lcd_rw_o, lcd_e_o, lcd_db_o
  );

  modport slave (
    input  data_i, data_valid_i,
    output ready_o, lcd_rs_o, lcd_rw_o, lcd_e_o, lcd_db_o
  );
endinterface

// File: rtl/lcd_bus_writer.sv
// Write-only HD44780 bus sequencer: setup, E pulse, hold, then an execution wait per symbol.
// Define LCD_NIBBLE_MODE_EN to drive the bus in 4-bit mode (two E pulses per symbol, one wait).
module lcd_bus_writer #(
  parameter int SETUP_CYC    = 4,
  parameter int E_HIGH_CYC   = 25,
  parameter int HOLD_CYC     = 4,
  parameter int CMD_WAIT_CYC = 4000,
  parameter int CLR_WAIT_CYC = 160000,
  parameter int CNT_W        = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  lcd_bus_writer_if.slave  bus,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_EHIGH = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  // A zero-length phase still occupies one cycle.
  localparam int SETUP_N = (SETUP_CYC    > 1) ? SETUP_CYC    : 1;
  localparam int EHIGH_N = (E_HIGH_CYC   > 1) ? E_HIGH_CYC   : 1;
  localparam int HOLD_N  = (HOLD_CYC     > 1) ? HOLD_CYC     : 1;
  localparam int CMD_N   = (CMD_WAIT_CYC > 1) ? CMD_WAIT_CYC : 1;
  localparam int CLR_N   = (CLR_WAIT_CYC > 1) ? CLR_WAIT_CYC : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_N - 1);
  localparam logic [CNT_W-1:0] EHIGH_LAST = CNT_W'(EHIGH_N - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_N - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_N - 1);
  localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_N - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [7:0]       db_q, db_d;
  logic             clr_q, clr_d;
`ifdef LCD_NIBBLE_MODE_EN
  logic             phase_q, phase_d;
  logic [3:0]       lo_q, lo_d;
`endif

  logic [CNT_W-1:0] wait_last;
  assign wait_last = clr_q ? CLR_LAST : CMD_LAST;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    e_d     = e_q;
    rs_d    = rs_q;
    db_d    = db_q;
    clr_d   = clr_q;
`ifdef LCD_NIBBLE_MODE_EN
    phase_d = phase_q;
    lo_d    = lo_q;
`endif
    case (state_q)
      S_IDLE: begin
        // ready rises on the first edge in IDLE, including the one after reset.
        ready_d = 1'b1;
        if (ready_q && bus.data_valid_i) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          ready_d = 1'b0;
          rs_d    = bus.data_i[8];
          // Clear display (0x01) and return home (0x02/0x03) need the long wait.
          clr_d   = !bus.data_i[8] && (bus.data_i[7:2] == 6'b000000);
`ifdef LCD_NIBBLE_MODE_EN
          db_d    = {bus.data_i[7:4], 4'h0};
          lo_d    = bus.data_i[3:0];
          phase_d = 1'b0;
`else
          db_d    = bus.data_i[7:0];
`endif
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_EHIGH;
          cnt_d   = '0;
          e_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EHIGH: begin
        if (cnt_q == EHIGH_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          e_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
`ifdef LCD_NIBBLE_MODE_EN
          if (!phase_q) begin
            state_d = S_SETUP;
            phase_d = 1'b1;
            db_d    = {lo_q, 4'h0};
          end else begin
            state_d = S_WAIT;
          end
`else
          state_d = S_WAIT;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == wait_last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        e_d     = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      clr_q   <= 1'b0;
`ifdef LCD_NIBBLE_MODE_EN
      phase_q <= 1'b0;
      lo_q    <= 4'h0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      db_q    <= db_d;
      clr_q   <= clr_d;
`ifdef LCD_NIBBLE_MODE_EN
      phase_q <= phase_d;
      lo_q    <= lo_d;
`endif
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.lcd_e_o  = e_q;
  assign bus.lcd_rs_o = rs_q;
  assign bus.lcd_db_o = db_q;
  assign bus.lcd_rw_o = 1'b0;
  assign state_o      = state_q;

`ifndef SYNTHESIS
  // The counter must reach every phase length without wrapping.
  localparam longint CNT_LIMIT = longint'(1) << CNT_W;
  localparam bit CFG_OK = (longint'(SETUP_CYC) < CNT_LIMIT) && (longint'(E_HIGH_CYC) < CNT_LIMIT) &&
                          (longint'(HOLD_CYC) < CNT_LIMIT) && (longint'(CMD_WAIT_CYC) < CNT_LIMIT) &&
                          (longint'(CLR_WAIT_CYC) < CNT_LIMIT);
  always_ff @(posedge clk_i) begin
    cfg_range_check: assert (CFG_OK)
      else $error("lcd_bus_writer: a timing parameter does not fit in CNT_W bits");
  end
`endif

endmodule
